// File: rtl/silife_spi_serializer.sv
// MSB-first SPI (mode 0) transmit stage for the MAX7219 driver.
// SCK = clk / (2*HALF_PERIOD); busy/done let the driver sequence words and chip-select.
module silife_spi_serializer #(
    parameter int WORD_BITS   = 16,
    parameter int HALF_PERIOD = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_BITS-1:0] i_word,
    input  logic                 i_start,
    output logic                 o_sck,
    output logic                 o_mosi,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BIT_W = $clog2(WORD_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic                 sck_q, sck_d;
    logic                 mosi_q, mosi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    shreg_d   = i_word;
                    mosi_d    = i_word[WORD_BITS-1];
                    busy_d    = 1'b1;
                    bit_cnt_d = BIT_LAST;
                    div_cnt_d = '0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sck_d     = 1'b1;
                    state_d   = HIGH;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            HIGH: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    sck_d     = 1'b0;
                    if (bit_cnt_q == '0) begin
                        // Final falling edge coincides with busy dropping and the done pulse.
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                        shreg_d   = shreg_q << 1;
                        mosi_d    = shreg_q[WORD_BITS-2];
                        state_d   = LOW;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_sck  = sck_q;
    assign o_mosi = mosi_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_silife_spi_serializer.sv
// Scoreboard bench for silife_spi_serializer: three instances cover the default,
// divided-clock (HALF_PERIOD=3) and 8-bit word configurations.
module tb_silife_spi_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic        start [3];
    logic [15:0] a_word, b_word;
    logic [7:0]  c_word;
    logic        sck   [3];
    logic        mosi  [3];
    logic        busy  [3];
    logic        done  [3];

    silife_spi_serializer #(.WORD_BITS(16), .HALF_PERIOD(1)) u_a (
        .clk(clk), .reset(rst[0]), .i_word(a_word), .i_start(start[0]),
        .o_sck(sck[0]), .o_mosi(mosi[0]), .o_busy(busy[0]), .o_done(done[0]));

    silife_spi_serializer #(.WORD_BITS(16), .HALF_PERIOD(3)) u_b (
        .clk(clk), .reset(rst[1]), .i_word(b_word), .i_start(start[1]),
        .o_sck(sck[1]), .o_mosi(mosi[1]), .o_busy(busy[1]), .o_done(done[1]));

    silife_spi_serializer #(.WORD_BITS(8), .HALF_PERIOD(1)) u_c (
        .clk(clk), .reset(rst[2]), .i_word(c_word), .i_start(start[2]),
        .o_sck(sck[2]), .o_mosi(mosi[2]), .o_busy(busy[2]), .o_done(done[2]));

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_q [3][$];
    int   rises    [3];
    int   dones    [3];
    int   busy_cyc [3];
    logic sck_p  [3];
    logic mosi_p [3];
    logic busy_p [3];

    // Samples on the falling clk edge: pops the expected bit on each SCK rise,
    // and flags MOSI moving anywhere other than an SCK fall or a busy transition.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst[k]) begin
                    if (sck[k] === 1'b1 && sck_p[k] === 1'b0) begin
                        rises[k]++;
                        n_tests++;
                        if (exp_q[k].size() == 0) begin
                            n_fail++;
                            $display("FAIL extra_rise[%0d]: SCK rise with mosi=%b, required no rise", k, mosi[k]);
                        end else begin
                            bit e;
                            e = exp_q[k].pop_front();
                            if (mosi[k] !== e) begin
                                n_fail++;
                                $display("FAIL mosi_bit[%0d] rise %0d: got %b, required %b", k, rises[k], mosi[k], e);
                            end
                        end
                    end
                    if (mosi[k] !== mosi_p[k] && !(sck_p[k] === 1'b1 && sck[k] === 1'b0)
                        && busy[k] === busy_p[k]) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL mosi_stable[%0d]: mosi %b->%b with sck %b->%b, required no change",
                                 k, mosi_p[k], mosi[k], sck_p[k], sck[k]);
                    end
                    if (done[k] === 1'b1) begin
                        dones[k]++;
                        n_tests++;
                        if (busy[k] !== 1'b0 || busy_p[k] !== 1'b1) begin
                            n_fail++;
                            $display("FAIL done_busy[%0d]: busy prev/now %b/%b, required 1/0", k, busy_p[k], busy[k]);
                        end
                    end
                    if (busy[k] === 1'b1) busy_cyc[k]++;
                end
                sck_p[k]  = sck[k];
                mosi_p[k] = mosi[k];
                busy_p[k] = busy[k];
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic drive_start(input int k, input logic [15:0] w);
        int nb;
        nb = (k == 2) ? 8 : 16;
        case (k)
            0: a_word = w;
            1: b_word = w;
            default: c_word = w[7:0];
        endcase
        start[k] = 1'b1;
        for (int i = nb - 1; i >= 0; i--) exp_q[k].push_back(w[i]);
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done[k] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL done_timeout[%0d]: no o_done within %0d cycles, required a pulse", k, limit);
        end
    endtask

    task automatic run_word(input int k, input logic [15:0] w, input int hp, input int nb, input string name);
        int  r0, d0, cyc;
        bit  ok;
        r0 = rises[k];
        d0 = dones[k];
        busy_cyc[k] = 0;
        drive_start(k, w);
        n_tests++;
        if (busy[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy_after_start: got %b, required 1", name, busy[k]);
        end
        wait_done(k, 2 * hp * nb + 10, cyc, ok);
        n_tests++;
        if (cyc != 2 * hp * nb) begin
            n_fail++;
            $display("FAIL %s_latency: done after %0d cycles, required %0d", name, cyc, 2 * hp * nb);
        end
        n_tests++;
        if (busy_cyc[k] != 2 * hp * nb) begin
            n_fail++;
            $display("FAIL %s_busy_len: got %0d, required %0d", name, busy_cyc[k], 2 * hp * nb);
        end
        n_tests++;
        if (rises[k] - r0 != nb || exp_q[k].size() != 0) begin
            n_fail++;
            $display("FAIL %s_rises: got %0d rises, %0d bits left, required %0d and 0",
                     name, rises[k] - r0, exp_q[k].size(), nb);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (done[k] !== 1'b0 || dones[k] - d0 != 1 || sck[k] !== 1'b0 || mosi[k] !== 1'b0 || busy[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_after: done=%b pulses=%0d sck=%b mosi=%b busy=%b, required 0 1 0 0 0",
                     name, done[k], dones[k] - d0, sck[k], mosi[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (sck[k] !== 1'b0 || mosi[k] !== 1'b0 || busy[k] !== 1'b0 || done[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_vals[%0d]: sck=%b mosi=%b busy=%b done=%b, required all 0",
                         k, sck[k], mosi[k], busy[k], done[k]);
            end
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        run_word(0, 16'h0C01, 1, 16, "single");
    endtask

    task automatic test_divider();
        run_word(1, 16'hA5F0, 3, 16, "divider");
    endtask

    task automatic test_narrow_word();
        run_word(2, 16'h0081, 1, 8, "narrow");
    endtask

    task automatic test_busy_ignore();
        int r0, cyc;
        bit ok;
        r0 = rises[0];
        busy_cyc[0] = 0;
        drive_start(0, 16'h3C5A);
        n_tests++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_busy_n1: got %b, required 1", busy[0]);
        end
        repeat (4) @(posedge clk);
        #1;
        a_word   = 16'hFFFF;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_done(0, 60, cyc, ok);
        n_tests++;
        if (rises[0] - r0 != 16 || busy_cyc[0] != 32 || exp_q[0].size() != 0) begin
            n_fail++;
            $display("FAIL ignore_single_word: rises=%0d busy=%0d left=%0d, required 16 32 0",
                     rises[0] - r0, busy_cyc[0], exp_q[0].size());
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (busy[0] !== 1'b0 || sck[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_idle: busy=%b sck=%b, required 0 0", busy[0], sck[0]);
        end
    endtask

    task automatic test_back_to_back();
        int r0, cyc;
        bit ok;
        r0 = rises[0];
        busy_cyc[0] = 0;
        drive_start(0, 16'h0B07);
        wait_done(0, 60, cyc, ok);
        n_tests++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_busy: got %b, required 0", busy[0]);
        end
        drive_start(0, 16'h0F00);
        n_tests++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: busy got %b, required 1", busy[0]);
        end
        wait_done(0, 60, cyc, ok);
        n_tests++;
        if (cyc != 32) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d, required 32", cyc);
        end
        n_tests++;
        if (rises[0] - r0 != 32 || busy_cyc[0] != 64 || exp_q[0].size() != 0) begin
            n_fail++;
            $display("FAIL b2b_totals: rises=%0d busy=%0d left=%0d, required 32 64 0",
                     rises[0] - r0, busy_cyc[0], exp_q[0].size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int  r0, d0;
        bit  hit;
        r0  = rises[0];
        hit = 1'b0;
        drive_start(0, 16'h1234);
        for (int i = 0; i < 40; i++) begin
            if (rises[0] - r0 >= 5) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL midreset_wait: saw %0d rises, required 5", rises[0] - r0);
        end
        d0     = dones[0];
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (sck[0] !== 1'b0 || mosi[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_vals: sck=%b mosi=%b busy=%b done=%b, required all 0",
                     sck[0], mosi[0], busy[0], done[0]);
        end
        rst[0] = 1'b0;
        exp_q[0].delete();
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (dones[0] != d0 || busy[0] !== 1'b0 || sck[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_quiet: done pulses=%0d busy=%b sck=%b, required 0 0 0",
                     dones[0] - d0, busy[0], sck[0]);
        end
        run_word(0, 16'h0102, 1, 16, "after_reset");
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k]      = 1'b1;
            start[k]    = 1'b0;
            rises[k]    = 0;
            dones[k]    = 0;
            busy_cyc[k] = 0;
            sck_p[k]    = 1'b0;
            mosi_p[k]   = 1'b0;
            busy_p[k]   = 1'b0;
        end
        a_word = '0;
        b_word = '0;
        c_word = '0;
        fork
            monitor();
        join_none
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_divider();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_narrow_word();
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
